// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, datapath select encodings and control FSM state/class types for the multi-cycle RV32I core.
package riscv_pkg;
  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_S     = 7'b0100011;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;
  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} alu_a_sel_e;
  typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR} alu_b_sel_e;
  typedef enum logic [1:0] {OP_ADD, OP_FUNCT, OP_CMP} alu_op_e;
  typedef enum logic [1:0] {PC_PLUS4, PC_TARGET, PC_JALR} pc_sel_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;
  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_WB, ST_TRAP} ctrl_state_e;
  typedef enum logic [3:0] {CL_R, CL_I, CL_LOAD, CL_S, CL_B, CL_JAL, CL_JALR, CL_LUI, CL_AUIPC} inst_class_e;
endpackage

// File: rtl/mc_main_decoder.sv
// mc_main_decoder: maps an opcode to its instruction class, immediate format and legality.
module mc_main_decoder import riscv_pkg::*; (
  input  logic [6:0]  opcode,
  output inst_class_e cls,
  output imm_type_e   imm_type,
  output logic        legal
);
  always_comb begin
    cls = CL_R;
    imm_type = IMM_NONE;
    legal = 1'b1;
    case (opcode)
      OPC_R:     cls = CL_R;
      OPC_I:     begin cls = CL_I;     imm_type = IMM_I; end
      OPC_LOAD:  begin cls = CL_LOAD;  imm_type = IMM_I; end
      OPC_S:     begin cls = CL_S;     imm_type = IMM_S; end
      OPC_B:     begin cls = CL_B;     imm_type = IMM_B; end
      OPC_JAL:   begin cls = CL_JAL;   imm_type = IMM_J; end
      OPC_JALR:  begin cls = CL_JALR;  imm_type = IMM_I; end
      OPC_LUI:   begin cls = CL_LUI;   imm_type = IMM_U; end
      OPC_AUIPC: begin cls = CL_AUIPC; imm_type = IMM_U; end
      default:   legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: fetch/decode/execute/mem/writeback sequencer for the multi-cycle RV32I core.
module multicycle_ctrl_fsm import riscv_pkg::*; #(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  output logic                 imem_req,
  input  logic                 imem_ready,
  input  logic [XLEN-1:0]      instr,
  output logic [XLEN-1:0]      ir,
  output logic [2:0]           imm_type,
  output logic [1:0]           alu_a_sel,
  output logic [1:0]           alu_b_sel,
  output logic [1:0]           alu_op,
  input  logic                 branch_taken,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ready,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic                 illegal_instr,
  output logic [INSTRET_W-1:0] instret
);
  ctrl_state_e          state_q, state_d;
  logic [XLEN-1:0]      ir_q, ir_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 illegal_q, illegal_d;
  logic                 done;
  inst_class_e          cls;
  imm_type_e            dec_imm;
  logic                 legal;

  mc_main_decoder u_dec (
    .opcode   (ir_q[6:0]),
    .cls      (cls),
    .imm_type (dec_imm),
    .legal    (legal)
  );

  // done marks the retiring cycle: count it and sample run for the next step
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    instret_d = instret_q;
    illegal_d = illegal_q;
    done = 1'b0;
    imem_req = 1'b0;
    imm_type = IMM_NONE;
    alu_a_sel = A_RS1;
    alu_b_sel = B_RS2;
    alu_op = OP_ADD;
    pc_we = 1'b0;
    pc_sel = PC_PLUS4;
    dmem_req = 1'b0;
    dmem_we = 1'b0;
    rf_we = 1'b0;
    wb_sel = WB_ALU;
    case (state_q)
      ST_IDLE: state_d = run ? ST_FETCH : ST_IDLE;
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_d = imem_ready ? instr : ir_q;
        state_d = imem_ready ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        state_d = legal ? ST_EXECUTE : ST_TRAP;
        illegal_d = illegal_q | ~legal;
      end
      ST_EXECUTE: begin
        imm_type = dec_imm;
        alu_a_sel = cls == CL_LUI ? A_ZERO : cls == CL_AUIPC ? A_PC : A_RS1;
        alu_b_sel = cls inside {CL_I, CL_LOAD, CL_S, CL_LUI, CL_AUIPC} ? B_IMM : B_RS2;
        alu_op = cls inside {CL_R, CL_I} ? OP_FUNCT : cls == CL_B ? OP_CMP : OP_ADD;
        state_d = cls inside {CL_LOAD, CL_S} ? ST_MEM : ST_WB;
        pc_we = cls == CL_B;
        pc_sel = cls == CL_B && branch_taken ? PC_TARGET : PC_PLUS4;
        done = cls == CL_B;
      end
      ST_MEM: begin
        imm_type = dec_imm;
        dmem_req = 1'b1;
        dmem_we = cls == CL_S;
        pc_we = dmem_ready && cls == CL_S;
        done = dmem_ready && cls == CL_S;
        state_d = dmem_ready ? ST_WB : ST_MEM;
      end
      ST_WB: begin
        imm_type = dec_imm;
        rf_we = 1'b1;
        pc_we = 1'b1;
        wb_sel = cls == CL_LOAD ? WB_MEM : cls inside {CL_JAL, CL_JALR} ? WB_PC4 : WB_ALU;
        pc_sel = cls == CL_JAL ? PC_TARGET : cls == CL_JALR ? PC_JALR : PC_PLUS4;
        done = 1'b1;
      end
      default: state_d = ST_TRAP;
    endcase
    if (done) begin
      instret_d = instret_q + INSTRET_W'(1);
      state_d = run ? ST_FETCH : ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ir_q <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  assign ir = ir_q;
  assign instret = instret_q;
  assign illegal_instr = illegal_q;
endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Main control FSM for the multi-cycle RV32I core. It fetches an instruction over a simple request/ready handshake and latches it into its own instruction register (IR). It then sequences the shared datapath (ALU, immediate generator, register file, PC, data memory) through decode, execute, memory and writeback steps. It selects the immediate format for the immediate generator, counts retired instructions and traps on unsupported opcodes.

Parameters:
XLEN, 32, instruction/datapath width
INSTRET_W, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  1 = start or continue fetching; 0 = go to IDLE after the current instruction
imem_req  out  1  instruction fetch request
imem_ready  in  1  instr is valid this cycle
instr  in  XLEN  fetched instruction word
ir  out  XLEN  latched instruction register
imm_type  out  3  immediate format select: NONE/I/S/B/U/J
alu_a_sel  out  2  ALU operand A select: RS1/PC/ZERO
alu_b_sel  out  2  ALU operand B select: RS2/IMM/FOUR
alu_op  out  2  ADD / FUNCT (decode funct3/funct7) / CMP
branch_taken  in  1  ALU compare result, sampled in EXECUTE for branches
pc_we  out  1  PC write strobe
pc_sel  out  2  next-PC select: PLUS4/TARGET (pc+imm)/JALR ((rs1+imm)&~1)
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store)
dmem_ready  in  1  data access complete
rf_we  out  1  register file write strobe; the register file ignores rd=x0
wb_sel  out  2  writeback select: ALU/MEM/PC4
illegal_instr  out  1  sticky trap flag
instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset (async, rst_n=0): state=IDLE immediately.
  - ir=0, instret=0, illegal_instr=0.
  - All strobes 0 (imem_req, pc_we, rf_we, dmem_req, dmem_we).
  - All selects 0.
  - Reset asserted mid-operation aborts the instruction; strobes drop in the same cycle.
- Output style: outputs are combinational from (state, ir); no registered-output latency.
  - Exception: pc_sel in EXECUTE for a branch follows branch_taken in the same cycle.
- Strobes: pc_we and rf_we are single-cycle pulses. dmem_req is held until dmem_ready.
- IDLE: all strobes 0. run=1 -> FETCH. imem_ready is ignored in IDLE.
- FETCH: imem_req=1.
  - Held while imem_ready=0.
  - On imem_ready=1: ir<=instr, go to DECODE.
- DECODE: classify ir[6:0].
  - Supported opcodes: R 0110011, I 0010011, LOAD 0000011, S 0100011, B 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Any other opcode: illegal_instr<=1, go to TRAP.
  - Otherwise go to EXECUTE.
- EXECUTE, per instruction class:
  - R: A=RS1, B=RS2, op=FUNCT; -> WB.
  - I: A=RS1, B=IMM, op=FUNCT, imm=I; -> WB.
  - LOAD: A=RS1, B=IMM, op=ADD, imm=I; -> MEM.
  - S: A=RS1, B=IMM, op=ADD, imm=S; -> MEM.
  - LUI: A=ZERO, B=IMM, imm=U; -> WB.
  - AUIPC: A=PC, B=IMM, imm=U; -> WB.
  - JAL: imm=J; -> WB.
  - JALR: imm=I; -> WB.
  - B: op=CMP, imm=B, pc_we=1, pc_sel=branch_taken?TARGET:PLUS4, instret++; -> FETCH if run else IDLE.
- MEM: dmem_req=1; dmem_we=1 for stores only.
  - Held until dmem_ready.
  - Load -> WB.
  - Store: pc_we=1, pc_sel=PLUS4, instret++; -> FETCH if run else IDLE.
- WB: rf_we=1, pc_we=1, instret++.
  - wb_sel: MEM for loads, PC4 for JAL/JALR, otherwise ALU.
  - pc_sel: TARGET for JAL, JALR for JALR, otherwise PLUS4.
  - Next state: FETCH if run else IDLE.
- TRAP: all strobes 0; the FSM stays in TRAP until reset.
- Minimum latency (zero-wait memories):
  - Branch: 3 cycles.
  - ALU, LUI, AUIPC, jumps, stores: 4 cycles.
  - Loads: 5 cycles.
- run=0 mid-instruction: the instruction completes, then the FSM enters IDLE. run is sampled only at the end of an instruction.
- instret wraps from 2^INSTRET_W-1 to 0 without a flag.
- ir changes only on FETCH completion.

Decomposition:
- Shared package riscv_pkg:
  - Opcode localparams.
  - Enums: imm_type_e, alu_a_sel_e, alu_b_sel_e, alu_op_e, pc_sel_e, wb_sel_e, ctrl_state_e (IDLE, FETCH, DECODE, EXECUTE, MEM, WB, TRAP).
  - imm_type_e is also consumed by the immediate generator select.
- Sub-module mc_main_decoder: combinational; maps ir opcode -> instruction class, imm_type, legal flag. The FSM instantiates it once.

Test Plan:
1. Reset, then run=1 -> IDLE then FETCH with imem_req=1; instret=0, illegal_instr=0; rst_n=0 mid-FETCH drops imem_req in the same cycle.
2. addi x1,x0,5 (0x00500093), imem_ready immediate -> FETCH/DECODE/EXECUTE/WB, imm_type=I, alu_b_sel=IMM, one rf_we and one pc_we pulse in WB, instret=1 after 4 cycles.
3. lw x2,4(x1) (0x0040A103), dmem_ready after 3 wait cycles -> dmem_req high 4 cycles, dmem_we=0, then WB with wb_sel=MEM; total 8 cycles.
4. sw x2,8(x1) (0x0020A423) -> imm_type=S, dmem_we=1, pc_we in MEM on ready, no rf_we.
5. beq x0,x0,+8 (0x00000463): branch_taken=1 -> pc_sel=TARGET, pc_we in EXECUTE, 3 cycles; repeat with branch_taken=0 -> pc_sel=PLUS4; run=0 during EXECUTE -> IDLE afterwards.
6. Illegal 0xFFFFFFFF -> TRAP, illegal_instr=1, no imem_req until reset; jal x1,+16 (0x010000EF) -> wb_sel=PC4, pc_sel=TARGET, imm_type=J.
